park_pwd_entry: RTL and testbench



---
 rtl/park_pkg.sv | 26 ++
 rtl/park_in_sync.sv | 32 +++
 rtl/park_pwd_entry.sv | 194 +++++++++++++++++++
 tb/tb_park_pwd_entry.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/park_pkg.sv
// Shared definitions for the car park controller: entry state encoding,
// digit width and default timing constants used by the keypad front-end
// and the park FSM.
package park_pkg;

  localparam int unsigned DIGIT_W            = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;
  localparam int unsigned DEF_MAX_FAIL       = 3;
  localparam int unsigned DEF_LOCKOUT_CYCLES = 5000;

  typedef enum logic [2:0] {
    StIdle,
    StDigit1,
    StDigit2,
    StWaitResult,
    StLocked
  } park_state_e;

  // Width of a counter that must reach the larger of two cycle limits.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/park_in_sync.sv
// Two-flop input synchroniser with optional rising-edge detection.
// Level mode: 2 cycles latency. Edge mode: registered one-cycle pulse,
// 3 cycles latency, so a held level produces a single pulse.
module park_in_sync #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic s1_q, s2_q, s3_q, pulse_q;

  // Synchroniser chain plus delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pulse_q <= s2_q & ~s3_q;
    end
  end

  assign dout = EDGE ? pulse_q : s2_q;

endmodule

// File: rtl/park_pwd_entry.sv
// Keypad front-end for the car park controller. Arms on the entrance sensor,
// collects two digits, presents them with a one-cycle pwd_valid strobe,
// counts rejected attempts and enforces a timed lockout.
// Optional build macro PARK_KEY_SYNC_EN: synchronise sensor_entrance,
// key_valid and key_clear (the latter two edge-detected).
module park_pwd_entry
  import park_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned MAX_FAIL       = DEF_MAX_FAIL,
  parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sensor_entrance,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               key_clear,
  input  logic               result_valid,
  input  logic               pwd_ok,
  output logic [DIGIT_W-1:0] password_1,
  output logic [DIGIT_W-1:0] password_2,
  output logic               pwd_valid,
  output logic               entry_busy,
  output logic               timeout,
  output logic               locked,
  output logic [1:0]         fail_cnt
);

  localparam int unsigned        TimerW      = timer_width(TIMEOUT_CYCLES, LOCKOUT_CYCLES);
  localparam logic [TimerW-1:0]  TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0]  LockoutLast = TimerW'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]         MaxFail     = 2'(MAX_FAIL);

  logic sens, kv, kc;

`ifdef PARK_KEY_SYNC_EN
  park_in_sync #(.EDGE(1'b0)) u_sync_sens (
    .clk   (clk),
    .reset (reset),
    .din   (sensor_entrance),
    .dout  (sens)
  );
  park_in_sync #(.EDGE(1'b1)) u_sync_kv (
    .clk   (clk),
    .reset (reset),
    .din   (key_valid),
    .dout  (kv)
  );
  park_in_sync #(.EDGE(1'b1)) u_sync_kc (
    .clk   (clk),
    .reset (reset),
    .din   (key_clear),
    .dout  (kc)
  );
`else
  assign sens = sensor_entrance;
  assign kv   = key_valid;
  assign kc   = key_clear;
`endif

  park_state_e        state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [DIGIT_W-1:0] d1_q, d1_d, d2_q, d2_d;
  logic [DIGIT_W-1:0] pw1_q, pw1_d, pw2_q, pw2_d;
  logic               pend_q, pend_d;  // d2 accepted, present on next edge
  logic               pv_q, pv_d, to_q, to_d;
  logic [1:0]         fail_q, fail_d, fail_inc;
  logic               expire;

  assign expire   = (state_q == StLocked) ? (timer_q == LockoutLast) : (timer_q == TimeoutLast);
  assign fail_inc = (fail_q >= MaxFail) ? MaxFail : fail_q + 2'd1;

  // Next-state, timer and output register updates.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    pw1_d   = pw1_q;
    pw2_d   = pw2_q;
    pend_d  = 1'b0;
    pv_d    = 1'b0;
    to_d    = 1'b0;
    fail_d  = fail_q;
    if (state_q != StIdle) timer_d = timer_q + TimerW'(1);
    unique case (state_q)
      StIdle: begin
        if (sens) begin
          state_d = StDigit1;
          timer_d = '0;
        end
      end
      StDigit1: begin
        if (kc) begin
          timer_d = '0;
        end else if (kv) begin
          d1_d    = key_code;
          state_d = StDigit2;
          timer_d = '0;
        end else if (expire) begin
          to_d    = 1'b1;
          state_d = StIdle;
          timer_d = '0;
        end
      end
      StDigit2: begin
        if (pend_q) begin
          pw1_d   = d1_q;
          pw2_d   = d2_q;
          pv_d    = 1'b1;
          state_d = StWaitResult;
          timer_d = '0;
        end else if (kc) begin
          d1_d    = '0;
          state_d = StDigit1;
          timer_d = '0;
        end else if (kv) begin
          d2_d    = key_code;
          pend_d  = 1'b1;
          timer_d = '0;
        end else if (expire) begin
          to_d    = 1'b1;
          state_d = StIdle;
          timer_d = '0;
        end
      end
      StWaitResult: begin
        if (result_valid) begin
          timer_d = '0;
          if (pwd_ok) begin
            fail_d  = '0;
            state_d = StIdle;
          end else begin
            fail_d  = fail_inc;
            state_d = (fail_inc == MaxFail) ? StLocked : StDigit1;
          end
        end else if (expire) begin
          to_d    = 1'b1;
          state_d = StIdle;
          timer_d = '0;
        end
      end
      StLocked: begin
        if (expire) begin
          fail_d  = '0;
          state_d = StIdle;
          timer_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  // State and registered outputs; reset takes effect without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      pw1_q   <= '0;
      pw2_q   <= '0;
      pend_q  <= 1'b0;
      pv_q    <= 1'b0;
      to_q    <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      pw1_q   <= pw1_d;
      pw2_q   <= pw2_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      to_q    <= to_d;
      fail_q  <= fail_d;
    end
  end

  assign password_1 = pw1_q;
  assign password_2 = pw2_q;
  assign pwd_valid  = pv_q;
  assign timeout    = to_q;
  assign fail_cnt   = fail_q;
  assign entry_busy = (state_q == StDigit1) || (state_q == StDigit2) ||
                      (state_q == StWaitResult);
  assign locked     = (state_q == StLocked);

endmodule

// File: tb/tb_park_pwd_entry.sv
// Self-checking bench for park_pwd_entry (default build, no input sync).
// Directed vector table, hand-written timing corner cases and a random
// phase checked against a behavioural model of the entry rules.
module tb_park_pwd_entry;

  localparam int TO = 20;
  localparam int MF = 3;
  localparam int LK = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_entrance = 1'b0, key_valid = 1'b0, key_clear = 1'b0;
  logic [1:0] key_code = 2'd0;
  logic       result_valid = 1'b0, pwd_ok = 1'b0;
  logic [1:0] password_1, password_2, fail_cnt;
  logic       pwd_valid, entry_busy, timeout, locked;

  park_pwd_entry #(
    .TIMEOUT_CYCLES (TO),
    .MAX_FAIL       (MF),
    .LOCKOUT_CYCLES (LK)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sensor_entrance (sensor_entrance),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .key_clear       (key_clear),
    .result_valid    (result_valid),
    .pwd_ok          (pwd_ok),
    .password_1      (password_1),
    .password_2      (password_2),
    .pwd_valid       (pwd_valid),
    .entry_busy      (entry_busy),
    .timeout         (timeout),
    .locked          (locked),
    .fail_cnt        (fail_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase of the entry dialogue and cycles spent in it.
  localparam int P_IDLE = 0, P_D1 = 1, P_D2 = 2, P_WAIT = 3, P_LOCK = 4;
  int m_ph, m_age, m_d1, m_d2, m_fails, e_pw1, e_pw2;
  bit m_show, e_pv, e_to;

  task automatic model_reset();
    m_ph = P_IDLE; m_age = 0; m_d1 = 0; m_d2 = 0; m_fails = 0;
    m_show = 0; e_pw1 = 0; e_pw2 = 0; e_pv = 0; e_to = 0;
  endtask

  task automatic model_step(input bit s, input bit kv, input bit kc, input int code,
                            input bit rv, input bit ok);
    int  lim, nph;
    bit  out_of_time, restart;
    lim         = (m_ph == P_LOCK) ? LK : TO;
    out_of_time = (m_age + 1 >= lim);  // this is the last allowed cycle
    nph = m_ph; restart = 0; e_pv = 0; e_to = 0;
    case (m_ph)
      P_IDLE: if (s) nph = P_D1;
      P_D1: begin
        if (kc) restart = 1;
        else if (kv) begin m_d1 = code; nph = P_D2; end
        else if (out_of_time) begin e_to = 1; nph = P_IDLE; end
      end
      P_D2: begin
        if (m_show) begin
          e_pw1 = m_d1; e_pw2 = m_d2; e_pv = 1; m_show = 0; nph = P_WAIT;
        end else if (kc) nph = P_D1;
        else if (kv) begin m_d2 = code; m_show = 1; restart = 1; end
        else if (out_of_time) begin e_to = 1; nph = P_IDLE; end
      end
      P_WAIT: begin
        if (rv) begin
          if (ok) begin m_fails = 0; nph = P_IDLE; end
          else begin
            m_fails = (m_fails + 1 > MF) ? MF : m_fails + 1;
            nph = (m_fails == MF) ? P_LOCK : P_D1;
          end
        end else if (out_of_time) begin e_to = 1; nph = P_IDLE; end
      end
      default: if (out_of_time) begin m_fails = 0; nph = P_IDLE; end
    endcase
    if (nph != m_ph || restart) m_age = 0;
    else if (m_ph != P_IDLE) m_age++;
    m_ph = nph;
  endtask

  task automatic compare_model();
    check("rnd_busy", entry_busy, (m_ph == P_D1 || m_ph == P_D2 || m_ph == P_WAIT));
    check("rnd_locked", locked, (m_ph == P_LOCK));
    check("rnd_fail_cnt", fail_cnt, m_fails);
    check("rnd_pwd_valid", pwd_valid, e_pv);
    check("rnd_timeout", timeout, e_to);
    check("rnd_password_1", password_1, e_pw1);
    check("rnd_password_2", password_2, e_pw2);
  endtask

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic tick(input bit s = 0, input bit kv = 0, input bit kc = 0, input int code = 0,
                      input bit rv = 0, input bit ok = 0);
    sensor_entrance = s; key_valid = kv; key_clear = kc; key_code = 2'(code);
    result_valid = rv; pwd_ok = ok;
    model_step(s, kv, kc, code, rv, ok);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    bit s, kv, kc; int code; bit rv, ok;
    int pw1, pw2; bit pv, busy, to, lk; int fails;
  } vec_t;

  vec_t vecs[$];
  bit   rs, rkv, rkc, rrv, rok;
  int   rcode, quiet;

  initial begin
    model_reset();
    // Normal entry then acceptance; key in IDLE ignored.
    vecs.push_back('{1,0,0,0,0,0, 0,0,0,1,0,0,0});
    vecs.push_back('{0,1,0,1,0,0, 0,0,0,1,0,0,0});
    vecs.push_back('{0,1,0,2,0,0, 0,0,0,1,0,0,0});
    vecs.push_back('{0,0,0,0,0,0, 1,2,1,1,0,0,0});
    vecs.push_back('{0,0,0,0,1,1, 1,2,0,0,0,0,0});
    vecs.push_back('{0,1,0,3,0,0, 1,2,0,0,0,0,0});
    // Clear in DIGIT2, then clear+key in the same cycle drops the key.
    vecs.push_back('{1,0,0,0,0,0, 1,2,0,1,0,0,0});
    vecs.push_back('{0,1,0,3,0,0, 1,2,0,1,0,0,0});
    vecs.push_back('{0,0,1,0,0,0, 1,2,0,1,0,0,0});
    vecs.push_back('{0,1,0,1,0,0, 1,2,0,1,0,0,0});
    vecs.push_back('{0,1,1,3,0,0, 1,2,0,1,0,0,0});
    vecs.push_back('{0,1,0,1,0,0, 1,2,0,1,0,0,0});
    vecs.push_back('{0,1,0,2,0,0, 1,2,0,1,0,0,0});
    vecs.push_back('{0,0,0,0,0,0, 1,2,1,1,0,0,0});
    vecs.push_back('{0,0,0,0,1,0, 1,2,0,1,0,0,1});
    vecs.push_back('{0,0,0,0,1,0, 1,2,0,1,0,0,1});

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", entry_busy, 0);
    check("reset_pwd_valid", pwd_valid, 0);
    check("reset_password_1", password_1, 0);
    check("reset_fail_cnt", fail_cnt, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      tick(vecs[i].s, vecs[i].kv, vecs[i].kc, vecs[i].code, vecs[i].rv, vecs[i].ok);
      check($sformatf("vec%0d_password_1", i), password_1, vecs[i].pw1);
      check($sformatf("vec%0d_password_2", i), password_2, vecs[i].pw2);
      check($sformatf("vec%0d_pwd_valid", i), pwd_valid, vecs[i].pv);
      check($sformatf("vec%0d_busy", i), entry_busy, vecs[i].busy);
      check($sformatf("vec%0d_timeout", i), timeout, vecs[i].to);
      check($sformatf("vec%0d_locked", i), locked, vecs[i].lk);
      check($sformatf("vec%0d_fail_cnt", i), fail_cnt, vecs[i].fails);
    end

    // Timeout in DIGIT1: clear restarts the timer, then TO idle cycles expire it.
    tick(.kc(1));
    idle(TO - 1);
    check("to_pre_busy", entry_busy, 1);
    check("to_pre_timeout", timeout, 0);
    tick();
    check("to_pulse", timeout, 1);
    check("to_busy", entry_busy, 0);
    check("to_password_1", password_1, 1);
    check("to_password_2", password_2, 2);
    check("to_fail_kept", fail_cnt, 1);
    tick();
    check("to_pulse_end", timeout, 0);

    // Key on the exact expiry cycle in DIGIT1 and DIGIT2; result on expiry in WAIT.
    tick(.s(1));
    idle(TO - 1);
    tick(.kv(1), .code(3));
    check("exp_key1_timeout", timeout, 0);
    check("exp_key1_busy", entry_busy, 1);
    idle(TO - 1);
    tick(.kv(1), .code(0));
    check("exp_key2_timeout", timeout, 0);
    tick();
    check("exp_pwd_valid", pwd_valid, 1);
    check("exp_password_1", password_1, 3);
    check("exp_password_2", password_2, 0);
    idle(TO - 1);
    tick(.rv(1), .ok(1));
    check("exp_res_timeout", timeout, 0);
    check("exp_res_busy", entry_busy, 0);
    check("exp_res_fail_cnt", fail_cnt, 0);

    // Lockout after MF rejections; sensor and keys ignored while locked.
    for (int i = 0; i < MF; i++) begin
      tick(.s(1));
      tick(.kv(1), .code(i));
      tick(.kv(1), .code(3 - i));
      tick();
      check($sformatf("lk%0d_pwd_valid", i), pwd_valid, 1);
      check($sformatf("lk%0d_password_1", i), password_1, i);
      tick(.rv(1), .ok(0));
      check($sformatf("lk%0d_fail_cnt", i), fail_cnt, i + 1);
      check($sformatf("lk%0d_locked", i), locked, (i == MF - 1));
    end
    for (int i = 0; i < LK - 1; i++) tick(.s(1), .kv(1), .code(1), .rv(1), .ok(1));
    check("lk_hold_locked", locked, 1);
    check("lk_hold_busy", entry_busy, 0);
    check("lk_hold_fail_cnt", fail_cnt, MF);
    check("lk_hold_password_1", password_1, 2);
    tick();
    check("lk_end_locked", locked, 0);
    check("lk_end_fail_cnt", fail_cnt, 0);

    // Asynchronous reset in DIGIT2 between clock edges.
    tick(.s(1));
    tick(.kv(1), .code(2));
    tick(.kv(1), .code(1));
    tick();
    tick(.rv(1), .ok(0));
    tick(.kv(1), .code(3));
    check("ar_pre_busy", entry_busy, 1);
    check("ar_pre_fail_cnt", fail_cnt, 1);
    sensor_entrance = 0; key_valid = 0; key_clear = 0; result_valid = 0;
    #2 reset = 1'b1;
    #1;
    check("ar_busy", entry_busy, 0);
    check("ar_fail_cnt", fail_cnt, 0);
    check("ar_password_1", password_1, 0);
    check("ar_password_2", password_2, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    // Random phase against the model, with quiet stretches to force timeouts.
    quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      if (quiet == 0 && $urandom_range(0, 59) == 0) quiet = $urandom_range(18, 45);
      if (quiet > 0) begin
        quiet--;
        rs = 0; rkv = 0; rkc = 0; rrv = 0;
      end else begin
        rs  = ($urandom_range(0, 3) == 0);
        rkv = ($urandom_range(0, 4) == 0);
        rkc = ($urandom_range(0, 19) == 0);
        rrv = ($urandom_range(0, 5) == 0);
      end
      rok   = ($urandom_range(0, 2) == 0);
      rcode = $urandom_range(0, 3);
      tick(rs, rkv, rkc, rcode, rrv, rok);
      compare_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
